// File: rtl/fft_iter_pkg.sv
// ---------------------------------------------------------------------------
// fft_iter_pkg
// Shared definitions for the iterative FFT core front/back ends.
//   loader_state_t : sequencing states of the input loader
//   MAX_AWL        : widest address the bit-reversal helper supports
//   bitrev()       : reverses the low 'awl' bits of an address
// ---------------------------------------------------------------------------
package fft_iter_pkg;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    KICK,
    WAIT_ACK,
    WAIT_REL
  } loader_state_t;

  localparam int MAX_AWL = 16;

  // Shifts the source out LSB-first into the result, so after 'awl' steps
  // bit 0 of the input lands in bit awl-1 of the output.
  function automatic logic [MAX_AWL-1:0] bitrev(input logic [MAX_AWL-1:0] n,
                                                input int awl);
    logic [MAX_AWL-1:0] src;
    logic [MAX_AWL-1:0] r;
    src = n;
    r   = '0;
    for (int i = 0; i < MAX_AWL; i++) begin
      if (i < awl) begin
        r   = {r[MAX_AWL-2:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reverse_unit.sv
// ---------------------------------------------------------------------------
// bit_reverse_unit
// Combinational AWL-bit address reversal, shared by the FFT loader and
// unloader.
//   addr     : natural-order address
//   rev_addr : addr with its AWL bits reversed
// ---------------------------------------------------------------------------
module bit_reverse_unit
  import fft_iter_pkg::*;
#(
  parameter int AWL = 5
) (
  input  logic [AWL-1:0] addr,
  output logic [AWL-1:0] rev_addr
);

  assign rev_addr = AWL'(bitrev(MAX_AWL'(addr), AWL));

endmodule

// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
// Streams complex samples into the FFT core's input RAM two at a time,
// (bit-reversed) addressing, then kicks the core and waits for it to take
// and release the RAM before accepting the next frame.
//   CLK, RST        : clock, synchronous active-high reset
//   EN              : global enable, freezes everything when low
//   s_valid/s_ready/s_data/s_last : input sample stream
//   o_A_DATA/o_B_DATA/o_A_ADDR/o_B_ADDR/o_RAM_Wr : core input-RAM write port
//   i_RAM_BLOCK     : core is reading the input RAM
//   o_START         : one-cycle core start pulse
//   o_frame_err     : one-cycle pulse when s_last disagrees with frame length
// ---------------------------------------------------------------------------
module fft_input_loader
  import fft_iter_pkg::*;
#(
  parameter int IWL         = 32,
  parameter int AWL         = 5,
  parameter int BIT_REVERSE = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [IWL-1:0] s_data,
  input  logic           s_last,
  output logic [IWL-1:0] o_A_DATA,
  output logic [IWL-1:0] o_B_DATA,
  output logic [AWL-1:0] o_A_ADDR,
  output logic [AWL-1:0] o_B_ADDR,
  output logic           o_RAM_Wr,
  input  logic           i_RAM_BLOCK,
  output logic           o_START,
  output logic           o_frame_err
);

  localparam logic [AWL-1:0] LAST_IDX  = '1;
  localparam logic [AWL-1:0] LAST_EVEN = {{(AWL-1){1'b1}}, 1'b0};
  // The odd partner of an even address: LSB in natural order, MSB when
  // bit-reversed.
  localparam logic [AWL-1:0] ODD_BIT   = (BIT_REVERSE != 0) ?
                                         (AWL'(1) << (AWL-1)) : AWL'(1);

  loader_state_t  state_q, state_d;
  logic [AWL-1:0] n_q, n_d;
  logic [IWL-1:0] held_q, held_d;
  logic [IWL-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [AWL-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic           wr_q, wr_d, start_q, start_d, err_q, err_d;

  logic [AWL-1:0] even_idx, even_rev, even_addr, odd_addr;
  logic           xfer, do_write;
  logic [IWL-1:0] pair_a, pair_b;

  // Every write targets the pair containing n, whose even member is n with
  // the LSB cleared; one reversal serves both addresses.
  assign even_idx = {n_q[AWL-1:1], 1'b0};

  bit_reverse_unit #(.AWL(AWL)) u_bit_reverse (
    .addr     (even_idx),
    .rev_addr (even_rev)
  );

  assign even_addr = (BIT_REVERSE != 0) ? even_rev : even_idx;
  assign odd_addr  = even_addr | ODD_BIT;

  assign s_ready = EN & (state_q == FILL) & ~RST;
  assign xfer    = s_valid & s_ready;

  // Pulses are held in their registers while EN is low and only exposed
  // once enabled, so a pending write or start is delayed, never dropped.
  assign o_RAM_Wr    = wr_q & EN;
  assign o_START     = start_q & EN;
  assign o_frame_err = err_q & EN;
  assign o_A_DATA    = a_data_q;
  assign o_B_DATA    = b_data_q;
  assign o_A_ADDR    = a_addr_q;
  assign o_B_ADDR    = b_addr_q;

  // Next-state logic: pairs samples, decides which pair word to write,
  // handles early/missing s_last, then sequences the core handoff.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    held_d   = held_q;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    wr_d     = 1'b0;
    start_d  = 1'b0;
    err_d    = 1'b0;
    do_write = 1'b0;
    pair_a   = '0;
    pair_b   = '0;

    case (state_q)
      FILL: begin
        if (xfer) begin
          if (!n_q[0]) begin
            if (!s_last) begin
              held_d = s_data;
              n_d    = n_q + 1'b1;
            end else begin
              // Frame ended on an even sample: partner is zero.
              do_write = 1'b1;
              pair_a   = s_data;
              err_d    = 1'b1;
              if (n_q == LAST_EVEN) begin
                state_d = KICK;
              end else begin
                n_d     = n_q + AWL'(2);
                state_d = PAD;
              end
            end
          end else begin
            do_write = 1'b1;
            pair_a   = held_q;
            pair_b   = s_data;
            if (n_q == LAST_IDX) begin
              state_d = KICK;
              err_d   = ~s_last;
            end else begin
              n_d = n_q + 1'b1;
              if (s_last) begin
                err_d   = 1'b1;
                state_d = PAD;
              end
            end
          end
        end
      end

      PAD: begin
        do_write = 1'b1;
        if (n_q == LAST_EVEN) begin
          state_d = KICK;
        end else begin
          n_d = n_q + AWL'(2);
        end
      end

      KICK: begin
        start_d = 1'b1;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (i_RAM_BLOCK) state_d = WAIT_REL;
      end

      WAIT_REL: begin
        if (!i_RAM_BLOCK) begin
          n_d     = '0;
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase

    if (do_write) begin
      wr_d     = 1'b1;
      a_data_d = pair_a;
      b_data_d = pair_b;
      a_addr_d = even_addr;
      b_addr_d = odd_addr;
    end
  end

  // State and output registers; EN low freezes all of them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FILL;
      n_q      <= '0;
      held_q   <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      wr_q     <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (EN) begin
      state_q  <= state_d;
      n_q      <= n_d;
      held_q   <= held_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      wr_q     <= wr_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_input_loader
// Drives a bit-reversed and a natural-order loader with the same stream and
// compares logged writes, START and frame-error pulses against a frame-level
// reference model.
// ---------------------------------------------------------------------------
module tb_fft_input_loader;

  localparam int IWL = 32;
  localparam int AWL = 3;
  localparam int N   = 8;
  localparam int NP  = N / 2;

  typedef struct {
    int             cyc;
    logic [IWL-1:0] a;
    logic [IWL-1:0] b;
    logic [AWL-1:0] aa;
    logic [AWL-1:0] ba;
  } wr_rec_t;

  typedef struct {
    int             cyc;
    logic [IWL-1:0] d;
    logic           last;
  } hs_rec_t;

  typedef struct {
    int nsamp;
    int last_at;
    int en_gap;
    bit rnd;
    int hold0;
    int hold1;
    bit exp_err;
  } frame_vec_t;

  logic           CLK = 1'b0;
  logic           RST, EN, s_valid, s_last, i_RAM_BLOCK;
  logic [IWL-1:0] s_data;

  logic           rdy    [2];
  logic [IWL-1:0] a_data [2];
  logic [IWL-1:0] b_data [2];
  logic [AWL-1:0] a_addr [2];
  logic [AWL-1:0] b_addr [2];
  logic           wr     [2];
  logic           start  [2];
  logic           ferr   [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  hs_rec_t hs_q [$];
  wr_rec_t wq   [2][$];
  int      st_q [2][$];
  int      er_q [2][$];

  always #5 CLK = ~CLK;

  // Index 0: bit-reversed addressing, index 1: natural order.
  fft_input_loader #(.IWL(IWL), .AWL(AWL), .BIT_REVERSE(1)) dut_rev (
    .CLK(CLK), .RST(RST), .EN(EN),
    .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data), .s_last(s_last),
    .o_A_DATA(a_data[0]), .o_B_DATA(b_data[0]),
    .o_A_ADDR(a_addr[0]), .o_B_ADDR(b_addr[0]), .o_RAM_Wr(wr[0]),
    .i_RAM_BLOCK(i_RAM_BLOCK), .o_START(start[0]), .o_frame_err(ferr[0])
  );

  fft_input_loader #(.IWL(IWL), .AWL(AWL), .BIT_REVERSE(0)) dut_nat (
    .CLK(CLK), .RST(RST), .EN(EN),
    .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data), .s_last(s_last),
    .o_A_DATA(a_data[1]), .o_B_DATA(b_data[1]),
    .o_A_ADDR(a_addr[1]), .o_B_ADDR(b_addr[1]), .o_RAM_Wr(wr[1]),
    .i_RAM_BLOCK(i_RAM_BLOCK), .o_START(start[1]), .o_frame_err(ferr[1])
  );

  always @(posedge CLK) cyc <= cyc + 1;

  // Mid-cycle observer: logs handshakes and every output event with its cycle.
  always @(negedge CLK) begin
    if (s_valid && rdy[0]) hs_q.push_back('{cyc, s_data, s_last});
    for (int d = 0; d < 2; d++) begin
      if (wr[d])    wq[d].push_back('{cyc, a_data[d], b_data[d], a_addr[d], b_addr[d]});
      if (start[d]) st_q[d].push_back(cyc);
      if (ferr[d])  er_q[d].push_back(cyc);
    end
  end

  // Reference address: reversal by arithmetic on the bit weights.
  function automatic logic [AWL-1:0] ref_addr(input int n, input bit brev);
    int r;
    r = 0;
    if (!brev) return AWL'(n);
    for (int i = 0; i < AWL; i++) r += ((n >> i) & 1) * (1 << (AWL - 1 - i));
    return AWL'(r);
  endfunction

  // A frame is well-formed only when s_last marks exactly sample N-1.
  function automatic bit ref_err(input int last_at);
    return last_at != N - 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearLogs();
    hs_q.delete();
    for (int d = 0; d < 2; d++) begin
      wq[d].delete();
      st_q[d].delete();
      er_q[d].delete();
    end
  endtask

  // Offers nsamp samples; EN drops for 3 cycles before sample en_gap.
  task automatic applyStimulus(input frame_vec_t v, input int idx);
    bit ok;
    clearLogs();
    for (int i = 0; i < v.nsamp; i++) begin
      if (v.en_gap == i) begin
        EN = 1'b0;
        repeat (3) tick();
        EN = 1'b1;
      end
      if (v.rnd) repeat ($urandom_range(0, 2)) tick();
      s_valid = 1'b1;
      s_data  = v.rnd ? IWL'($urandom) : IWL'(32'h11 * (i + 1));
      s_last  = (i == v.last_at);
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge CLK);
        ok = rdy[0];
        tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) begin
        checkOutput($sformatf("f%0d_ready_timeout", idx), 64'd0, 64'd1);
        return;
      end
    end
  endtask

  // Builds the expected frame (zero-padded to N) and compares both DUT logs.
  task automatic checkFrame(input frame_vec_t v, input int idx, input bit exp_err);
    logic [IWL-1:0] p [N];
    int ecyc [NP];
    int m;
    m = hs_q.size();
    checkOutput($sformatf("f%0d_accepted", idx), 64'(m), 64'(v.nsamp));
    if (m != v.nsamp || m == 0) return;
    for (int i = 0; i < N; i++) p[i] = (i < m) ? hs_q[i].d : '0;
    for (int k = 0; k < NP; k++) begin
      if (2 * k + 1 < m)  ecyc[k] = hs_q[2*k+1].cyc + 1 + ((v.en_gap == 2 * k + 2) ? 3 : 0);
      else if (2 * k < m) ecyc[k] = hs_q[2*k].cyc + 1;
      else                ecyc[k] = ecyc[k-1] + 1;
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("f%0d_d%0d_nwrites", idx, d), 64'(wq[d].size()), 64'(NP));
      for (int k = 0; k < NP && k < wq[d].size(); k++) begin
        checkOutput($sformatf("f%0d_d%0d_pair%0d_data", idx, d, k),
                    {wq[d][k].a, wq[d][k].b}, {p[2*k], p[2*k+1]});
        checkOutput($sformatf("f%0d_d%0d_pair%0d_addr", idx, d, k),
                    64'({wq[d][k].aa, wq[d][k].ba}),
                    64'({ref_addr(2 * k, d == 0), ref_addr(2 * k + 1, d == 0)}));
        checkOutput($sformatf("f%0d_d%0d_pair%0d_cycle", idx, d, k),
                    64'(wq[d][k].cyc), 64'(ecyc[k]));
      end
      checkOutput($sformatf("f%0d_d%0d_start_count", idx, d), 64'(st_q[d].size()), 64'd1);
      if (st_q[d].size() > 0)
        checkOutput($sformatf("f%0d_d%0d_start_cycle", idx, d), 64'(st_q[d][0]), 64'(ecyc[NP-1] + 1));
      checkOutput($sformatf("f%0d_d%0d_err_count", idx, d), 64'(er_q[d].size()), 64'(exp_err));
      if (exp_err && er_q[d].size() > 0)
        checkOutput($sformatf("f%0d_d%0d_err_cycle", idx, d), 64'(er_q[d][0]), 64'(hs_q[m-1].cyc + 1));
    end
  endtask

  // Core handoff: no readiness until RAM_BLOCK rises and falls again.
  task automatic releaseCore(input int hold0, input int hold1, input int idx);
    int seen;
    seen = 0;
    for (int t = 0; t < hold0; t++) begin
      @(negedge CLK);
      if (rdy[0] || rdy[1]) seen++;
      tick();
    end
    i_RAM_BLOCK = 1'b1;
    for (int t = 0; t < hold1; t++) begin
      @(negedge CLK);
      if (rdy[0] || rdy[1]) seen++;
      tick();
    end
    checkOutput($sformatf("f%0d_ready_while_busy", idx), 64'(seen), 64'd0);
    i_RAM_BLOCK = 1'b0;
    tick();
    @(negedge CLK);
    checkOutput($sformatf("f%0d_ready_after_release", idx), 64'({rdy[0], rdy[1]}), 64'b11);
    tick();
  endtask

  task automatic runFrame(input frame_vec_t v, input int idx, input bit exp_err);
    applyStimulus(v, idx);
    for (int t = 0; t < 40 && st_q[0].size() == 0; t++) tick();
    tick();
    checkFrame(v, idx, exp_err);
    releaseCore(v.hold0, v.hold1, idx);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_vec_t vecs [7];
    frame_vec_t rv;
    int m;

    vecs[0] = '{8,  7, -1, 1'b0, 10, 20, 1'b0};
    vecs[1] = '{3,  2, -1, 1'b0,  2,  2, 1'b1};
    vecs[2] = '{8, -1, -1, 1'b0,  2,  2, 1'b1};
    vecs[3] = '{8,  7,  4, 1'b0,  2,  2, 1'b0};
    vecs[4] = '{2,  1, -1, 1'b0,  2,  2, 1'b1};
    vecs[5] = '{7,  6, -1, 1'b0,  1,  1, 1'b1};
    vecs[6] = '{4,  3,  2, 1'b0,  1,  1, 1'b1};

    RST = 1'b1; EN = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    s_data = '0; i_RAM_BLOCK = 1'b0;
    repeat (3) tick();
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_d%0d_outputs", d),
                  64'({rdy[d], wr[d], start[d], ferr[d]}), 64'd0);
      checkOutput($sformatf("reset_d%0d_addr_data", d),
                  {a_data[d], 26'd0, a_addr[d], b_addr[d]}, 64'd0);
    end
    tick();
    RST = 1'b0;
    tick();
    @(negedge CLK);
    checkOutput("ready_after_reset", 64'({rdy[0], rdy[1]}), 64'b11);
    tick();

    for (int i = 0; i < 7; i++) runFrame(vecs[i], i, vecs[i].exp_err);

    // Reset after five samples: partial frame dropped, no START.
    rv = '{5, -1, -1, 1'b0, 0, 0, 1'b0};
    applyStimulus(rv, 50);
    RST = 1'b1;
    tick();
    @(negedge CLK);
    checkOutput("midreset_ready", 64'({rdy[0], rdy[1]}), 64'd0);
    tick();
    RST = 1'b0;
    repeat (10) tick();
    checkOutput("midreset_writes", 64'(wq[0].size()), 64'd2);
    checkOutput("midreset_start", 64'(st_q[0].size() + st_q[1].size()), 64'd0);
    checkOutput("midreset_err", 64'(er_q[0].size() + er_q[1].size()), 64'd0);
    runFrame(vecs[0], 51, vecs[0].exp_err);

    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(1, N);
      rv.nsamp   = m;
      rv.last_at = (m < N) ? m - 1 : (($urandom_range(0, 1) == 1) ? N - 1 : -1);
      rv.en_gap  = -1;
      if (m > 2 && $urandom_range(0, 1) == 1) rv.en_gap = 2 * $urandom_range(1, (m - 1) / 2);
      rv.rnd     = 1'b1;
      rv.hold0   = $urandom_range(0, 3);
      rv.hold1   = $urandom_range(1, 4);
      rv.exp_err = ref_err(rv.last_at);
      runFrame(rv, 100 + i, rv.exp_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
